// File: rtl/instr_prefetch_queue.sv
// Prefetch queue ahead of IF: streams words from instruction memory into a small FIFO under a
// credit that counts the in-flight read. Define PFQ_STATS_EN to add stat_fetch/stat_flush counters.
module instr_prefetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk1,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  input  logic                   halt,
  output logic                   out_valid,
  output logic [31:0]            out_ir,
  output logic [31:0]            out_npc,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] occupancy
`ifdef PFQ_STATS_EN
  ,
  output logic [31:0]            stat_fetch,
  output logic [15:0]            stat_flush
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       ir_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q [DEPTH];

  logic              credit_ok;
  logic              issue;
  logic              push;
  logic              pop;
  logic              head_vld;
  logic [ADDR_W-1:0] head_npc;

  // The outstanding read already owns a slot, so a request is only made when its data is sure to fit.
  assign credit_ok = (count_q + CNT_W'(inflight_q)) < CNT_W'(DEPTH);
  assign issue     = !rst && !halt && !redirect && credit_ok;
  assign push      = inflight_q && !redirect;
  assign head_vld  = !rst && (count_q != '0);
  assign pop       = out_valid && out_ready;

  assign imem_req  = issue;
  assign imem_addr = rst ? RESET_PC : fetch_pc_q;
  assign out_valid = head_vld && !redirect;
  assign head_npc  = pc_mem_q[rd_ptr_q] + ADDR_W'(1);
  assign out_ir    = head_vld ? ir_mem_q[rd_ptr_q] : '0;
  assign out_npc   = head_vld ? 32'(head_npc) : '0;
  assign occupancy = rst ? '0 : count_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = issue;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    end
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Payload storage carries no reset; validity is tracked entirely by count and inflight.
  always_ff @(posedge clk1) begin
    if (issue) begin
      inflight_pc_q <= fetch_pc_q;
    end
    if (push) begin
      ir_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q] <= inflight_pc_q;
    end
  end

`ifdef PFQ_STATS_EN
  logic [31:0] stat_fetch_q;
  logic [15:0] stat_flush_q;

  always_ff @(posedge clk1) begin
    if (rst) begin
      stat_fetch_q <= '0;
      stat_flush_q <= '0;
    end else begin
      if (push) begin
        stat_fetch_q <= stat_fetch_q + 32'd1;
      end
      if (redirect && (stat_flush_q != 16'hFFFF)) begin
        stat_flush_q <= stat_flush_q + 16'd1;
      end
    end
  end

  assign stat_fetch = stat_fetch_q;
  assign stat_flush = stat_flush_q;
`endif

endmodule
